regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WIDTH, default 16, data width of each register.
REQ-002 Parameter REGBITS, default 4, address width; depth is 2^REGBITS registers.
REQ-003 Parameter ZERO_REG, default 1: 1 hardwires register 0 to zero, 0 makes register 0 ordinary.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 regwrite  input  1  write enable.
REQ-008 wa  input  REGBITS  write address.
REQ-009 wd  input  WIDTH  write data.
REQ-010 ra1, ra2  input  REGBITS  read addresses, ports 1 and 2.
REQ-011 reserve  input  1  scoreboard reserve strobe.
REQ-012 rsv_addr  input  REGBITS  register to mark pending.
REQ-013 rd1, rd2  output  WIDTH  registered read data.
REQ-014 busy1, busy2  output  1  combinational pending flag for ra1 and ra2.
REQ-015 ready  output  1  high once the post-reset clear sweep has completed.

Function
REQ-016 The state machine SHALL have two states, CLEAR and READY; reset forces CLEAR with sweep counter 0.
REQ-017 In CLEAR, each rising edge with reset low SHALL write 0 to register[counter] and increment the counter.
REQ-018 The edge that clears register 2^REGBITS-1 SHALL move the state to READY; ready SHALL equal (state==READY).
REQ-019 ready SHALL therefore rise exactly 2^REGBITS rising edges after reset deasserts: 16 for REGBITS=4.
REQ-020 In CLEAR, regwrite and reserve SHALL be ignored, and rd1 and rd2 SHALL be loaded with 0.
REQ-021 In READY, regwrite=1 SHALL write wd to register[wa] at the rising edge.
REQ-022 With ZERO_REG=1, a write to address 0 SHALL be discarded.
REQ-023 Reads SHALL be synchronous: rd1 and rd2 after edge N reflect ra1 and ra2 sampled at edge N; latency is 1 cycle.
REQ-024 Write-first bypass: if regwrite and wa==raX at the same edge, with the write not discarded, rdX SHALL load wd, not the old contents.
REQ-025 With ZERO_REG=1, a read of address 0 SHALL return 0 regardless of bypass.
REQ-026 Both read ports SHALL be independent; ra1==ra2 SHALL return identical data on both ports.
REQ-027 Scoreboard: one busy bit per register, all cleared by reset and held clear during CLEAR.
REQ-028 In READY, reserve=1 SHALL set busy[rsv_addr]; regwrite=1 SHALL clear busy[wa].
REQ-029 If reserve and regwrite target the same address at the same edge, set SHALL win and busy stays 1.
REQ-030 With ZERO_REG=1, busy[0] SHALL never set.
REQ-031 busy1 SHALL equal busy[ra1] and busy2 SHALL equal busy[ra2], combinationally from current state.
REQ-032 Writing a register that is not busy SHALL be legal and leave its busy bit 0.

Reset
REQ-033 reset=1 at a rising edge SHALL set rd1=0, rd2=0, ready=0, all busy bits=0, counter=0, state=CLEAR; reset has priority over all other inputs.
REQ-034 Reset asserted mid-sweep or in READY SHALL restart the sweep from register 0.
REQ-035 Register contents SHALL be undefined until cleared by the sweep, never observable because rd outputs are 0 in CLEAR.

Verification
REQ-036 Release reset, drive regwrite=1 wa=3 wd=16'hBEEF throughout the sweep -> ready rises after exactly 16 edges, and a subsequent read of reg 3 returns 0.
REQ-037 In READY, write wa=5 wd=16'h1234 with ra1=5 at the same edge -> rd1=16'h1234 after that edge (bypass); ra2=5 at the next edge -> rd2=16'h1234.
REQ-038 Write wa=0 wd=16'hFFFF, then ra1=0 -> rd1=0; repeat with ZERO_REG=0 -> rd1=16'hFFFF.
REQ-039 reserve rsv_addr=7, then ra1=7 -> busy1=1; regwrite wa=7 -> busy1=0; same-edge reserve and regwrite on 7 -> busy1=1.
REQ-040 Assert reset for 1 cycle at sweep count 9 -> ready=0, busy all 0, and ready rises 16 edges after the re-release.
REQ-041 WIDTH=32, REGBITS=5: write 32'hDEADBEEF to reg 31, read back on both ports -> both return 32'hDEADBEEF; sweep takes 32 edges.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: two-read / one-write register file with a per-register
// pending (busy) scoreboard. After reset the storage is swept to zero one
// register per clock. Writes and reservations are accepted only once that
// sweep is complete and ready is high.
module regfile_sb #(
  parameter int WIDTH    = 16,
  parameter int REGBITS  = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               regwrite,
  input  logic [REGBITS-1:0] wa,
  input  logic [WIDTH-1:0]   wd,
  input  logic [REGBITS-1:0] ra1,
  input  logic [REGBITS-1:0] ra2,
  input  logic               reserve,
  input  logic [REGBITS-1:0] rsv_addr,
  output logic [WIDTH-1:0]   rd1,
  output logic [WIDTH-1:0]   rd2,
  output logic               busy1,
  output logic               busy2,
  output logic               ready
);

  localparam int DEPTH = 1 << REGBITS;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t             state_reg;
  logic [REGBITS-1:0] count_reg;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]   busy_vec;

  // A user write is accepted only in READY and never into a hardwired zero register.
  logic wr_zero;
  logic user_we;
  assign wr_zero = ZERO_REG && (wa == '0);
  assign user_we = (state_reg == READY) && regwrite && !wr_zero;

  // The single storage write port is shared by the clear sweep and user writes.
  logic               mem_we;
  logic [REGBITS-1:0] mem_wa;
  logic [WIDTH-1:0]   mem_wd;

  // Select the storage write source: sweep in CLEAR, user port in READY.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wa;
    mem_wd = wd;
    if (!reset) begin
      if (state_reg == CLEAR) begin
        mem_we = 1'b1;
        mem_wa = count_reg;
        mem_wd = '0;
      end else if (user_we) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage array; it has no reset because the sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Sweep controller: CLEAR walks every address once, then it parks in READY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= CLEAR;
      count_reg <= '0;
    end else if (state_reg == CLEAR) begin
      count_reg <= count_reg + REGBITS'(1);
      if (count_reg == REGBITS'(DEPTH - 1)) begin
        state_reg <= READY;
      end
    end
  end

  assign ready = (state_reg == READY);

  // Two identical synchronous read ports, each with write-first bypass.
  logic [REGBITS-1:0] ra_arr [2];
  assign ra_arr[0] = ra1;
  assign ra_arr[1] = ra2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [WIDTH-1:0] rd_next;
      logic [WIDTH-1:0] rd_reg;

      // Zero-register and CLEAR forcing take precedence over the bypass path.
      always_comb begin
        rd_next = mem[ra_arr[gi]];
        if (user_we && (wa == ra_arr[gi])) begin
          rd_next = wd;
        end
        if (ZERO_REG && (ra_arr[gi] == '0)) begin
          rd_next = '0;
        end
        if (state_reg == CLEAR) begin
          rd_next = '0;
        end
      end

      // Registered read data, cleared by reset.
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_reg <= '0;
        end else begin
          rd_reg <= rd_next;
        end
      end
    end
  endgenerate

  assign rd1 = g_rd[0].rd_reg;
  assign rd2 = g_rd[1].rd_reg;

  // One pending bit per register; a reservation beats a same-edge write.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      localparam bit NEVER_SET = ZERO_REG && (gi == 0);
      logic busy_reg;
      logic set_b;
      logic clr_b;

      assign set_b = (state_reg == READY) && reserve &&
                     (rsv_addr == REGBITS'(gi)) && !NEVER_SET;
      assign clr_b = (state_reg == READY) && regwrite && (wa == REGBITS'(gi));

      // Busy bits stay clear through reset and the whole sweep.
      always_ff @(posedge clk) begin
        if (reset || (state_reg == CLEAR)) begin
          busy_reg <= 1'b0;
        end else if (set_b) begin
          busy_reg <= 1'b1;
        end else if (clr_b) begin
          busy_reg <= 1'b0;
        end
      end

      assign busy_vec[gi] = busy_reg;
    end
  endgenerate

  assign busy1 = busy_vec[ra1];
  assign busy2 = busy_vec[ra2];

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: three instances (default, ZERO_REG=0, 32x32).
// Expected observations are queued when stimulus is applied and compared
// once the clock edge that produces them has passed.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two 16-bit instances
  logic        reset, regwrite, reserve;
  logic [3:0]  wa, ra1, ra2, rsv_addr;
  logic [15:0] wd;
  logic [15:0] rd1_a, rd2_a, rd1_z, rd2_z;
  logic        busy1_a, busy2_a, ready_a, busy1_z, busy2_z, ready_z;

  // Stimulus for the 32-bit / 32-entry instance
  logic        reset_w, regwrite_w, reserve_w;
  logic [4:0]  wa_w, ra1_w, ra2_w, rsv_addr_w;
  logic [31:0] wd_w;
  logic [31:0] rd1_w, rd2_w;
  logic        busy1_w, busy2_w, ready_w;

  regfile_sb dut_a (
    .clk(clk), .reset(reset), .regwrite(regwrite), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .reserve(reserve), .rsv_addr(rsv_addr),
    .rd1(rd1_a), .rd2(rd2_a), .busy1(busy1_a), .busy2(busy2_a), .ready(ready_a)
  );

  regfile_sb #(.ZERO_REG(1'b0)) dut_z (
    .clk(clk), .reset(reset), .regwrite(regwrite), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .reserve(reserve), .rsv_addr(rsv_addr),
    .rd1(rd1_z), .rd2(rd2_z), .busy1(busy1_z), .busy2(busy2_z), .ready(ready_z)
  );

  regfile_sb #(.WIDTH(32), .REGBITS(5)) dut_w (
    .clk(clk), .reset(reset_w), .regwrite(regwrite_w), .wa(wa_w), .wd(wd_w),
    .ra1(ra1_w), .ra2(ra2_w), .reserve(reserve_w), .rsv_addr(rsv_addr_w),
    .rd1(rd1_w), .rd2(rd2_w), .busy1(busy1_w), .busy2(busy2_w), .ready(ready_w)
  );

  // Observation layout: {rd1[31:0], rd2[31:0], busy1, busy2, ready}
  localparam logic [66:0] M_ALL = {67{1'b1}};
  localparam logic [66:0] M_RD1 = {32'hFFFF_FFFF, 35'h0};
  localparam logic [66:0] M_RDY = 67'h1;

  typedef struct {
    string       name;
    int          sel;
    logic [66:0] exp;
    logic [66:0] mask;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  function automatic logic [66:0] mk(input logic [31:0] r1, input logic [31:0] r2,
                                     input logic b1, input logic b2, input logic rdy);
    return {r1, r2, b1, b2, rdy};
  endfunction

  function automatic logic [66:0] observe(input int sel);
    case (sel)
      0:       return {16'h0, rd1_a, 16'h0, rd2_a, busy1_a, busy2_a, ready_a};
      1:       return {16'h0, rd1_z, 16'h0, rd2_z, busy1_z, busy2_z, ready_z};
      default: return {rd1_w, rd2_w, busy1_w, busy2_w, ready_w};
    endcase
  endfunction

  task automatic push_exp(input string name, input int sel,
                          input logic [66:0] exp, input logic [66:0] mask);
    sb_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    e.mask = mask;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sb_t e;
    logic [66:0] got;
    reset = 1'b1; regwrite = 1'b1; wa = 4'd3; wd = 16'hBEEF;
    reserve = 1'b1; rsv_addr = 4'd3; ra1 = 4'd3; ra2 = 4'd3;
    for (int s = 0; s < 2; s++) begin
      push_exp("reset_a", 0, mk(0, 0, 0, 0, 0), M_ALL);
      push_exp("reset_z", 1, mk(0, 0, 0, 0, 0), M_ALL);
      tick();
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        got = observe(e.sel);
        n_checks++;
        if ((got & e.mask) !== (e.exp & e.mask)) begin
          n_fail++;
          $display("FAIL %s: got %h required %h", e.name, got & e.mask, e.exp & e.mask);
        end else $display("ok   %s: %h", e.name, got & e.mask);
      end
    end
  endtask

  task automatic test_sweep();
    sb_t e;
    logic [66:0] got;
    reset = 1'b0;
    for (int s = 0; s <= 16; s++) begin
      if (s < 16) begin
        push_exp($sformatf("sweep_edge%0d", s + 1), 0, mk(0, 0, 0, 0, s == 15), M_ALL);
        if (s == 15) push_exp("sweep_ready_z", 1, mk(0, 0, 0, 0, 1), M_RDY);
      end else begin
        regwrite = 1'b0; reserve = 1'b0;
        push_exp("sweep_reg3_zero", 0, mk(0, 0, 0, 0, 1), M_ALL);
      end
      tick();
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        got = observe(e.sel);
        n_checks++;
        if ((got & e.mask) !== (e.exp & e.mask)) begin
          n_fail++;
          $display("FAIL %s: got %h required %h", e.name, got & e.mask, e.exp & e.mask);
        end else $display("ok   %s: %h", e.name, got & e.mask);
      end
    end
  endtask

  task automatic test_bypass();
    sb_t e;
    logic [66:0] got;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin
          regwrite = 1'b1; wa = 4'd5; wd = 16'h1234; ra1 = 4'd5; ra2 = 4'd0;
          push_exp("bypass_rd1", 0, mk(16'h1234, 0, 0, 0, 1), M_ALL);
          push_exp("bypass_rd1_z", 1, mk(16'h1234, 0, 0, 0, 1), M_RD1);
        end
        1: begin
          regwrite = 1'b0; ra1 = 4'd0; ra2 = 4'd5;
          push_exp("readback_rd2", 0, mk(0, 16'h1234, 0, 0, 1), M_ALL);
        end
        2: begin
          regwrite = 1'b1; wa = 4'd6; wd = 16'hA5A5; ra1 = 4'd5; ra2 = 4'd6;
          push_exp("bypass_rd2", 0, mk(16'h1234, 16'hA5A5, 0, 0, 1), M_ALL);
        end
        default: begin
          regwrite = 1'b0; ra1 = 4'd6; ra2 = 4'd6;
          push_exp("same_addr_both", 0, mk(16'hA5A5, 16'hA5A5, 0, 0, 1), M_ALL);
        end
      endcase
      tick();
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        got = observe(e.sel);
        n_checks++;
        if ((got & e.mask) !== (e.exp & e.mask)) begin
          n_fail++;
          $display("FAIL %s: got %h required %h", e.name, got & e.mask, e.exp & e.mask);
        end else $display("ok   %s: %h", e.name, got & e.mask);
      end
    end
  endtask

  task automatic test_zero_reg();
    sb_t e;
    logic [66:0] got;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin
          regwrite = 1'b1; wa = 4'd0; wd = 16'hFFFF; ra1 = 4'd0; ra2 = 4'd0;
          push_exp("zero_write_bypass_a", 0, mk(0, 0, 0, 0, 1), M_ALL);
          push_exp("zero_write_bypass_z", 1, mk(16'hFFFF, 16'hFFFF, 0, 0, 1), M_ALL);
        end
        1: begin
          regwrite = 1'b0;
          push_exp("zero_read_a", 0, mk(0, 0, 0, 0, 1), M_ALL);
          push_exp("zero_read_z", 1, mk(16'hFFFF, 16'hFFFF, 0, 0, 1), M_ALL);
        end
        2: begin
          reserve = 1'b1; rsv_addr = 4'd0;
          push_exp("zero_reserve_a", 0, mk(0, 0, 0, 0, 1), M_ALL);
          push_exp("zero_reserve_z", 1, mk(16'hFFFF, 16'hFFFF, 1, 1, 1), M_ALL);
        end
        default: begin
          reserve = 1'b0; regwrite = 1'b1; wa = 4'd0; wd = 16'hFFFF;
          push_exp("zero_release_a", 0, mk(0, 0, 0, 0, 1), M_ALL);
          push_exp("zero_release_z", 1, mk(16'hFFFF, 16'hFFFF, 0, 0, 1), M_ALL);
        end
      endcase
      tick();
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        got = observe(e.sel);
        n_checks++;
        if ((got & e.mask) !== (e.exp & e.mask)) begin
          n_fail++;
          $display("FAIL %s: got %h required %h", e.name, got & e.mask, e.exp & e.mask);
        end else $display("ok   %s: %h", e.name, got & e.mask);
      end
    end
    regwrite = 1'b0;
  endtask

  task automatic test_scoreboard();
    sb_t e;
    logic [66:0] got;
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: begin
          regwrite = 1'b0; reserve = 1'b1; rsv_addr = 4'd7; ra1 = 4'd7; ra2 = 4'd6;
          push_exp("reserve7", 0, mk(0, 16'hA5A5, 1, 0, 1), M_ALL);
        end
        1: begin
          reserve = 1'b0; regwrite = 1'b1; wa = 4'd7; wd = 16'h0777;
          push_exp("write7_clears", 0, mk(16'h0777, 16'hA5A5, 0, 0, 1), M_ALL);
        end
        2: begin
          reserve = 1'b1; rsv_addr = 4'd7; regwrite = 1'b1; wa = 4'd7; wd = 16'h0778;
          push_exp("same_edge_set_wins", 0, mk(16'h0778, 16'hA5A5, 1, 0, 1), M_ALL);
        end
        3: begin
          reserve = 1'b0; regwrite = 1'b1; wa = 4'd6; wd = 16'h6666;
          push_exp("write_not_busy", 0, mk(16'h0778, 16'h6666, 1, 0, 1), M_ALL);
        end
        default: begin
          regwrite = 1'b0; reserve = 1'b1; rsv_addr = 4'd9; ra2 = 4'd9;
          push_exp("reserve9_both_busy", 0, mk(16'h0778, 0, 1, 1, 1), M_ALL);
        end
      endcase
      tick();
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        got = observe(e.sel);
        n_checks++;
        if ((got & e.mask) !== (e.exp & e.mask)) begin
          n_fail++;
          $display("FAIL %s: got %h required %h", e.name, got & e.mask, e.exp & e.mask);
        end else $display("ok   %s: %h", e.name, got & e.mask);
      end
    end
    reserve = 1'b0;
  endtask

  task automatic test_mid_reset();
    sb_t e;
    logic [66:0] got;
    // s=0 reset from READY, s=1..9 partial sweep, s=10 reset at count 9,
    // s=11..26 full sweep with writes/reserves ignored, s=27 readback.
    for (int s = 0; s <= 27; s++) begin
      if (s == 0 || s == 10) begin
        reset = 1'b1; ra1 = 4'd7; ra2 = 4'd9;
        push_exp($sformatf("midreset_s%0d", s), 0, mk(0, 0, 0, 0, 0), M_ALL);
      end else if (s < 10) begin
        reset = 1'b0;
        push_exp($sformatf("partial_sweep%0d", s), 0, mk(0, 0, 0, 0, 0), M_RDY);
      end else if (s < 27) begin
        reset = 1'b0; regwrite = 1'b1; wa = 4'd5; wd = 16'hBEEF;
        reserve = 1'b1; rsv_addr = 4'd7;
        push_exp($sformatf("resweep_edge%0d", s - 10), 0, mk(0, 0, 0, 0, s == 26), M_ALL);
      end else begin
        regwrite = 1'b0; reserve = 1'b0; ra1 = 4'd5; ra2 = 4'd7;
        push_exp("resweep_cleared", 0, mk(0, 0, 0, 0, 1), M_ALL);
      end
      tick();
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        got = observe(e.sel);
        n_checks++;
        if ((got & e.mask) !== (e.exp & e.mask)) begin
          n_fail++;
          $display("FAIL %s: got %h required %h", e.name, got & e.mask, e.exp & e.mask);
        end else $display("ok   %s: %h", e.name, got & e.mask);
      end
    end
  endtask

  task automatic test_wide();
    sb_t e;
    logic [66:0] got;
    // s=0 reset, s=1..32 sweep with writes ignored, s=33 write reg 31, s=34 readback.
    for (int s = 0; s <= 34; s++) begin
      if (s == 0) begin
        push_exp("wide_reset", 2, mk(0, 0, 0, 0, 0), M_ALL);
      end else if (s <= 32) begin
        reset_w = 1'b0;
        push_exp($sformatf("wide_sweep%0d", s), 2, mk(0, 0, 0, 0, s == 32), M_ALL);
      end else if (s == 33) begin
        regwrite_w = 1'b1; wa_w = 5'd31; wd_w = 32'hDEADBEEF; ra1_w = 5'd0; ra2_w = 5'd0;
        push_exp("wide_write31", 2, mk(0, 0, 0, 0, 1), M_ALL);
      end else begin
        regwrite_w = 1'b0; ra1_w = 5'd31; ra2_w = 5'd31;
        push_exp("wide_read31", 2, mk(32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1), M_ALL);
      end
      tick();
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        got = observe(e.sel);
        n_checks++;
        if ((got & e.mask) !== (e.exp & e.mask)) begin
          n_fail++;
          $display("FAIL %s: got %h required %h", e.name, got & e.mask, e.exp & e.mask);
        end else $display("ok   %s: %h", e.name, got & e.mask);
      end
    end
  endtask

  initial begin
    reset = 1'b1; regwrite = 1'b0; reserve = 1'b0;
    wa = '0; wd = '0; ra1 = '0; ra2 = '0; rsv_addr = '0;
    reset_w = 1'b1; regwrite_w = 1'b1; reserve_w = 1'b1;
    wa_w = 5'd31; wd_w = 32'hDEADBEEF; ra1_w = 5'd31; ra2_w = 5'd31; rsv_addr_w = 5'd31;
    test_reset();
    test_sweep();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_mid_reset();
    reserve_w = 1'b0;
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
